// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package mips_fetch_pkg;

  // Fetch FSM: RUN issues requests, MISS waits for the refill to complete.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MISS = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_miss_counter.sv
// Saturating event counter used to count instruction-cache misses.
module fetch_miss_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on each event, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC register, miss/stall/redirect control and IF/ID registers.
// Optional miss counter output is enabled by defining FETCH_MISS_CNT_EN.
//
// Handshake: an instruction is accepted into IF/ID on a clock edge where
// ic_req=1, ic_hit=1 and stall=0; stall=1 freezes IF/ID and the PC, and a
// redirect_valid pulse always wins over stall and squashes IF/ID.
module fetch_pc_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pc_inc,
  input  logic        ic_hit,
  input  logic [31:0] ic_instr,
  input  logic        ic_fill_done,
  output logic [31:0] ic_addr,
  output logic        ic_req,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
`ifdef FETCH_MISS_CNT_EN
  output logic [CNT_W-1:0] miss_cnt,
`endif
  output logic        dbg_state
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic         r_if_valid;
  logic         w_if_valid_next;
  logic [31:0]  r_if_pc;
  logic [31:0]  w_if_pc_next;
  logic [31:0]  r_if_instr;
  logic [31:0]  w_if_instr_next;
  logic         w_miss_evt;

  // State, PC and IF/ID registers; reset aborts any pending miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= NOP_INSTR;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_pc_next;
      r_if_valid <= w_if_valid_next;
      r_if_pc    <= w_if_pc_next;
      r_if_instr <= w_if_instr_next;
    end
  end

  // Next-state logic: redirect > stall > hit/miss; everything holds by default.
  always_comb begin
    w_next_state    = r_state;
    w_pc_next       = r_pc;
    w_if_valid_next = r_if_valid;
    w_if_pc_next    = r_if_pc;
    w_if_instr_next = r_if_instr;
    w_miss_evt      = 1'b0;
    if (redirect_valid) begin
      // Squash IF/ID even under stall; a MISS keeps waiting for its refill
      // unless the refill lands in this same cycle.
      w_pc_next       = redirect_pc;
      w_if_valid_next = 1'b0;
      if ((r_state == MISS) && ic_fill_done) begin
        w_next_state = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (stall) begin
            // A hit under stall is dropped and refetched; a miss still starts.
            if (!ic_hit) begin
              w_next_state = MISS;
              w_miss_evt   = 1'b1;
            end
          end else if (ic_hit) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = r_pc;
            w_if_instr_next = ic_instr;
            w_pc_next       = pc_inc;
          end else begin
            w_if_valid_next = 1'b0;
            w_next_state    = MISS;
            w_miss_evt      = 1'b1;
          end
        end
        MISS: begin
          if (!stall) begin
            w_if_valid_next = 1'b0;
          end
          if (ic_fill_done) begin
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

`ifdef FETCH_MISS_CNT_EN
  fetch_miss_counter #(
    .CNT_W(CNT_W)
  ) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_miss_evt),
    .o_cnt (miss_cnt)
  );
`endif

  assign ic_addr   = r_pc;
  assign ic_req    = (r_state == RUN);
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: vector table plus throughput and
// (with FETCH_MISS_CNT_EN) counter saturation sequences.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;
  localparam int          TB_CNT_W    = 4;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] inc;
    logic        hit;
    logic [31:0] instr;
    logic        fd;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;
  logic        ic_hit;
  logic [31:0] ic_instr;
  logic        ic_fill_done;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        dbg_state;
`ifdef FETCH_MISS_CNT_EN
  logic [TB_CNT_W-1:0] miss_cnt;
`endif

  int checks;
  int failures;
  vec_t vq[$];
  logic [31:0] exp_q[$];

  fetch_pc_ctrl #(
    .RESET_PC(TB_RESET_PC),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_inc        (pc_inc),
    .ic_hit        (ic_hit),
    .ic_instr      (ic_instr),
    .ic_fill_done  (ic_fill_done),
    .ic_addr       (ic_addr),
    .ic_req        (ic_req),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
`ifdef FETCH_MISS_CNT_EN
    .miss_cnt      (miss_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                     input logic [31:0] inc, input logic hit, input logic [31:0] instr,
                     input logic fd, input logic [31:0] ea, input logic er, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.inc = inc; v.hit = hit;
    v.instr = instr; v.fd = fd; v.e_addr = ea; v.e_req = er; v.e_valid = ev;
    v.e_pc = ep; v.e_instr = ei; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  // Driver: apply inputs before the edge, sample 1 time unit after it.
  task automatic drive_cycle(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                             input logic [31:0] inc, input logic hit, input logic [31:0] instr,
                             input logic fd);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    pc_inc = inc; ic_hit = hit; ic_instr = instr; ic_fill_done = fd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    pc_inc = '0; ic_hit = 1'b0; ic_instr = '0; ic_fill_done = 1'b0;
    @(negedge clk);

    // rst stall rv rpc inc hit instr fd | addr req valid if_pc if_instr cnt
    add(1,0,0,0,0,0,0,0,                    32'h100,1,0,32'h0,32'h0,0);
    add(0,0,0,0,32'h101,1,ins(32'h100),0,   32'h101,1,1,32'h100,ins(32'h100),0);
    add(0,0,0,0,32'h102,1,ins(32'h101),0,   32'h102,1,1,32'h101,ins(32'h101),0);
    add(0,0,0,0,32'h103,1,ins(32'h102),0,   32'h103,1,1,32'h102,ins(32'h102),0);
    add(0,0,0,0,32'h104,1,ins(32'h103),0,   32'h104,1,1,32'h103,ins(32'h103),0);
    for (int k = 0; k < 5; k++)
      add(0,0,0,0,0,0,0,0,                  32'h104,0,0,32'h103,ins(32'h103),1);
    add(0,0,0,0,0,0,0,1,                    32'h104,1,0,32'h103,ins(32'h103),1);
    add(0,0,0,0,32'h105,1,ins(32'h104),0,   32'h105,1,1,32'h104,ins(32'h104),1);
    add(0,0,0,0,32'h106,1,ins(32'h105),0,   32'h106,1,1,32'h105,ins(32'h105),1);
    for (int k = 0; k < 3; k++)
      add(0,1,0,0,32'h107,1,ins(32'h106),0, 32'h106,1,1,32'h105,ins(32'h105),1);
    add(0,0,0,0,32'h107,1,ins(32'h106),0,   32'h107,1,1,32'h106,ins(32'h106),1);
    add(0,1,1,32'h200,32'h108,1,ins(32'h107),0, 32'h200,1,0,32'h106,ins(32'h106),1);
    add(0,0,0,0,32'h201,1,ins(32'h200),0,   32'h201,1,1,32'h200,ins(32'h200),1);
    add(0,0,0,0,0,0,0,0,                    32'h201,0,0,32'h200,ins(32'h200),2);
    add(0,0,1,32'h300,0,0,0,0,              32'h300,0,0,32'h200,ins(32'h200),2);
    add(0,0,0,0,0,0,0,0,                    32'h300,0,0,32'h200,ins(32'h200),2);
    add(0,0,0,0,0,0,0,1,                    32'h300,1,0,32'h200,ins(32'h200),2);
    add(0,0,0,0,32'h301,1,ins(32'h300),0,   32'h301,1,1,32'h300,ins(32'h300),2);
    add(0,1,0,0,0,0,0,0,                    32'h301,0,1,32'h300,ins(32'h300),3);
    add(0,1,0,0,0,0,0,0,                    32'h301,0,1,32'h300,ins(32'h300),3);
    add(0,0,0,0,0,0,0,0,                    32'h301,0,0,32'h300,ins(32'h300),3);
    add(1,0,0,0,0,0,0,0,                    32'h100,1,0,32'h0,32'h0,0);
    add(0,1,0,0,32'h101,1,ins(32'h100),1,   32'h100,1,0,32'h0,32'h0,0);
    add(0,0,0,0,0,0,0,0,                    32'h100,0,0,32'h0,32'h0,1);
    add(0,0,1,32'h400,0,0,0,1,              32'h400,1,0,32'h0,32'h0,1);
    add(0,0,0,0,32'h401,1,ins(32'h400),0,   32'h401,1,1,32'h400,ins(32'h400),1);
    add(0,0,1,32'hFFFF_FFFF,32'h402,1,ins(32'h401),0, 32'hFFFF_FFFF,1,0,32'h400,ins(32'h400),1);
    add(0,0,0,0,32'h0,1,ins(32'hFFFF_FFFF),0, 32'h0,1,1,32'hFFFF_FFFF,ins(32'hFFFF_FFFF),1);

    foreach (vq[i]) begin
      drive_cycle(vq[i].rst, vq[i].stall, vq[i].rv, vq[i].rpc, vq[i].inc,
                  vq[i].hit, vq[i].instr, vq[i].fd);
      chk($sformatf("v%0d ic_addr", i),  ic_addr,            vq[i].e_addr);
      chk($sformatf("v%0d ic_req", i),   {31'b0, ic_req},    {31'b0, vq[i].e_req});
      chk($sformatf("v%0d state", i),    {31'b0, dbg_state}, {31'b0, ~vq[i].e_req});
      chk($sformatf("v%0d if_valid", i), {31'b0, if_valid},  {31'b0, vq[i].e_valid});
      chk($sformatf("v%0d if_pc", i),    if_pc,              vq[i].e_pc);
      chk($sformatf("v%0d if_instr", i), if_instr,           vq[i].e_instr);
`ifdef FETCH_MISS_CNT_EN
      chk($sformatf("v%0d miss_cnt", i), 32'(miss_cnt),      vq[i].e_cnt);
`endif
    end

    // Back-to-back hits after a redirect: one instruction per cycle, in order.
    drive_cycle(0,0,1,32'h500,0,0,0,0);
    chk("thr redirect valid", {31'b0, if_valid}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'h500 + 32'(k));
      drive_cycle(0,0,0,0,32'h501 + 32'(k),1,ins(32'h500 + 32'(k)),0);
      chk($sformatf("thr%0d if_valid", k), {31'b0, if_valid}, 32'h1);
      chk($sformatf("thr%0d ic_addr", k), ic_addr, 32'h501 + 32'(k));
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk($sformatf("thr%0d if_pc", k), if_pc, e);
        chk($sformatf("thr%0d if_instr", k), if_instr, ins(e));
      end
    end

`ifdef FETCH_MISS_CNT_EN
    // Saturation: 2^CNT_W+5 misses, each followed by its refill.
    drive_cycle(1,0,0,0,0,0,0,0);
    chk("sat reset cnt", 32'(miss_cnt), 32'h0);
    for (int k = 0; k < (1 << TB_CNT_W) + 5; k++) begin
      drive_cycle(0,0,0,0,0,0,0,0);
      drive_cycle(0,0,0,0,0,0,0,1);
      if (k == 13) chk("sat mid cnt", 32'(miss_cnt), 32'd14);
    end
    chk("sat final cnt", 32'(miss_cnt), 32'((1 << TB_CNT_W) - 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
